// File: rtl/decade_chain_ctrl_pkg.sv
// Shared types and constants for the decade counter chain controller.
// Holds the FSM state encoding and BCD digit constants.
package decade_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

endpackage

// File: rtl/decade_chain_ctrl_if.sv
// Command and display bundle between push-button pulse logic,
// the chain controller and the display driver.
interface decade_chain_ctrl_if
    import decade_pkg::*;
#(
    parameter int DIGITS = 4
);

    logic                        START;
    logic                        STOP;
    logic                        CLEAR;
    logic                        LAP;
    logic [DIGIT_W*DIGITS-1:0]   BCD;
    logic                        RUNNING;
    logic                        FROZEN;
    logic                        OVF;

    modport master (
        output START, STOP, CLEAR, LAP,
        input  BCD, RUNNING, FROZEN, OVF
    );

    modport slave (
        input  START, STOP, CLEAR, LAP,
        output BCD, RUNNING, FROZEN, OVF
    );

endinterface

// File: rtl/decade_chain_ctrl_digit.sv
// One BCD decade: counts 0..9 when enabled, wraps 9 -> 0.
// Synchronous clear wins over enable.
module bcd_digit
    import decade_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               CLR,
    output logic [DIGIT_W-1:0] Q,
    output logic               AT_MAX
);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    assign Q      = q_q;
    assign AT_MAX = (q_q == BCD_MAX);

    // Next digit value: clear, else increment with decade wrap.
    always_comb begin
        q_d = q_q;
        if (CLR) begin
            q_d = '0;
        end else if (EN) begin
            q_d = AT_MAX ? '0 : q_q + 1'b1;
        end
    end

    // Digit register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/decade_chain_ctrl.sv
// Run/stop/clear controller for a cascaded BCD counter chain with
// prescaled count ticks, lap freeze and sticky overflow.
module decade_chain_ctrl
    import decade_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic               CLK,
    input  logic               RST,
    decade_chain_ctrl_if.slave bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = DIGIT_W * DIGITS;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    state_e          state_q;
    state_e          state_d;
    logic [PW-1:0]   presc_q;
    logic [PW-1:0]   presc_d;
    logic [CW-1:0]   snap_q;
    logic [CW-1:0]   snap_d;
    logic            frozen_q;
    logic            frozen_d;
    logic            ovf_q;
    logic            ovf_d;

    logic [CW-1:0]     live;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] dig_en;
    logic [DIGITS:0]   carry;
    logic              running;
    logic              tick;
    logic              all_max;

    assign running = (state_q == ST_RUN);
    assign tick    = running && (presc_q == PRESC_LAST);
    assign all_max = carry[DIGITS];
    assign dig_en  = {DIGITS{tick}} & carry[DIGITS-1:0];

    // carry[i] is set when every digit below i sits at 9.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            carry[i+1] = carry[i] & at_max[i];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .CLK    (CLK),
            .RST    (RST),
            .EN     (dig_en[g]),
            .CLR    (bus.CLEAR),
            .Q      (live[DIGIT_W*g +: DIGIT_W]),
            .AT_MAX (at_max[g])
        );
    end

    // Next state: CLEAR beats STOP beats START.
    always_comb begin
        state_d = state_q;
        if (bus.CLEAR) begin
            state_d = ST_IDLE;
        end else if (bus.STOP) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else if (bus.START) begin
            state_d = ST_RUN;
        end
    end

    // Prescaler advances only in RUN and holds its phase in PAUSE.
    always_comb begin
        presc_d = presc_q;
        if (bus.CLEAR) begin
            presc_d = '0;
        end else if (running) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    // Lap snapshot toggle and sticky overflow on an all-9s tick.
    always_comb begin
        snap_d   = snap_q;
        frozen_d = frozen_q;
        ovf_d    = ovf_q;
        if (bus.CLEAR) begin
            snap_d   = '0;
            frozen_d = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            if (tick && all_max) begin
                ovf_d = 1'b1;
            end
            if (bus.LAP && (state_q != ST_IDLE)) begin
                if (frozen_q) begin
                    frozen_d = 1'b0;
                end else begin
                    frozen_d = 1'b1;
                    snap_d   = live;
                end
            end
        end
    end

    // Control registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            snap_q   <= '0;
            frozen_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            snap_q   <= snap_d;
            frozen_q <= frozen_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.BCD     = frozen_q ? snap_q : live;
    assign bus.RUNNING = running;
    assign bus.FROZEN  = frozen_q;
    assign bus.OVF     = ovf_q;

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Scoreboard bench for decade_chain_ctrl: directed scenarios plus
// random command pulses against an integer-count reference model.
module tb_decade_chain_ctrl;

    localparam int DIGITS   = 2;
    localparam int PRESCALE = 4;
    localparam int MODN     = 100;

    typedef enum {M_IDLE, M_RUN, M_PAUSE} mst_t;

    typedef struct {
        logic [7:0] bcd;
        logic       run;
        logic       frz;
        logic       ovf;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    mst_t m_st;
    int   m_cnt;
    int   m_pre;
    int   m_snap;
    bit   m_frz;
    bit   m_ovf;

    decade_chain_ctrl_if #(.DIGITS(DIGITS)) bus ();

    decade_chain_ctrl #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #20 CLK = ~CLK;

    function automatic logic [7:0] to_bcd(int v);
        logic [7:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st   = M_IDLE;
        m_cnt  = 0;
        m_pre  = 0;
        m_snap = 0;
        m_frz  = 0;
        m_ovf  = 0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.bcd = to_bcd(m_frz ? m_snap : m_cnt);
        e.run = (m_st == M_RUN);
        e.frz = m_frz;
        e.ovf = m_ovf;
        return e;
    endfunction

    // One clock edge of the reference behaviour.
    task automatic model_step(bit st, bit sp, bit cl, bit lp);
        mst_t ost;
        int   ocnt;
        bit   tick;
        ost  = m_st;
        ocnt = m_cnt;
        tick = (ost == M_RUN) && (m_pre == PRESCALE - 1);
        if (cl) begin
            model_reset();
            return;
        end
        if (ost == M_RUN) begin
            m_pre = (m_pre + 1) % PRESCALE;
            if (tick) begin
                m_cnt = (ocnt + 1) % MODN;
                if (ocnt == MODN - 1) m_ovf = 1;
            end
        end
        if (lp && ost != M_IDLE) begin
            if (m_frz) begin
                m_frz = 0;
            end else begin
                m_frz  = 1;
                m_snap = ocnt;
            end
        end
        if (sp) begin
            if (ost == M_RUN) m_st = M_PAUSE;
        end else if (st) begin
            m_st = M_RUN;
        end
    endtask

    task automatic cycle(bit st, bit sp, bit cl, bit lp);
        @(negedge CLK);
        RST       = 1'b0;
        bus.START = st;
        bus.STOP  = sp;
        bus.CLEAR = cl;
        bus.LAP   = lp;
        model_step(st, sp, cl, lp);
        sbq.push_back(model_out());
    endtask

    task automatic run(int n);
        repeat (n) cycle(0, 0, 0, 0);
    endtask

    task automatic after_edge();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST       = 1'b1;
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        bus.CLEAR = 1'b0;
        bus.LAP   = 1'b0;
        #1;
        chk("rst_bcd", bus.BCD, 8'h00);
        chk("rst_running", bus.RUNNING, 8'h00);
        chk("rst_frozen", bus.FROZEN, 8'h00);
        chk("rst_ovf", bus.OVF, 8'h00);
        model_reset();
        sbq.push_back(model_out());
    endtask

    // Monitor: compare DUT outputs after every edge with the queued model.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #5;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_bcd", bus.BCD, e.bcd);
                chk("sb_running", bus.RUNNING, e.run);
                chk("sb_frozen", bus.FROZEN, e.frz);
                chk("sb_ovf", bus.OVF, e.ovf);
            end
        end
    end

    // Stimulus.
    initial begin
        int k;
        bit st, sp, cl, lp;
        RST       = 1'b0;
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        bus.CLEAR = 1'b0;
        bus.LAP   = 1'b0;
        model_reset();
        #1 RST = 1'b1;
        #2;
        chk("init_bcd", bus.BCD, 8'h00);
        chk("init_running", bus.RUNNING, 8'h00);
        chk("init_frozen", bus.FROZEN, 8'h00);
        chk("init_ovf", bus.OVF, 8'h00);

        // Start and carry 09 -> 10.
        cycle(1, 0, 0, 0);
        run(39);
        after_edge();
        chk("t1_bcd09", bus.BCD, 8'h09);
        run(1);
        after_edge();
        chk("t1_bcd10", bus.BCD, 8'h10);
        chk("t1_running", bus.RUNNING, 8'h01);

        // Overflow and clear.
        run(356);
        after_edge();
        chk("t2_bcd99", bus.BCD, 8'h99);
        chk("t2_ovf0", bus.OVF, 8'h00);
        run(4);
        after_edge();
        chk("t2_wrap", bus.BCD, 8'h00);
        chk("t2_ovf1", bus.OVF, 8'h01);
        run(8);
        after_edge();
        chk("t2_ovf_sticky", bus.OVF, 8'h01);
        chk("t2_bcd02", bus.BCD, 8'h02);
        cycle(0, 0, 1, 0);
        after_edge();
        chk("t2_clr_ovf", bus.OVF, 8'h00);
        chk("t2_clr_run", bus.RUNNING, 8'h00);
        chk("t2_clr_bcd", bus.BCD, 8'h00);

        // Pause keeps the partial prescale period.
        cycle(1, 0, 0, 0);
        run(21);
        cycle(0, 1, 0, 0);
        after_edge();
        chk("t3_pause_run", bus.RUNNING, 8'h00);
        chk("t3_pause_bcd", bus.BCD, 8'h05);
        run(20);
        after_edge();
        chk("t3_hold_bcd", bus.BCD, 8'h05);
        cycle(1, 0, 0, 0);
        after_edge();
        chk("t3_resume_run", bus.RUNNING, 8'h01);
        run(1);
        after_edge();
        chk("t3_resume_1", bus.BCD, 8'h05);
        run(1);
        after_edge();
        chk("t3_resume_2", bus.BCD, 8'h06);

        // Lap freeze and release.
        run(24);
        after_edge();
        chk("t4_live12", bus.BCD, 8'h12);
        cycle(0, 0, 0, 1);
        after_edge();
        chk("t4_frozen1", bus.FROZEN, 8'h01);
        chk("t4_snap", bus.BCD, 8'h12);
        run(19);
        after_edge();
        chk("t4_hold", bus.BCD, 8'h12);
        cycle(0, 0, 0, 1);
        after_edge();
        chk("t4_frozen0", bus.FROZEN, 8'h00);
        chk("t4_live17", bus.BCD, 8'h17);

        // START+STOP+CLEAR together at 33.
        k = 0;
        while (m_cnt != 33 && k < 400) begin
            cycle(0, 0, 0, 0);
            k++;
        end
        after_edge();
        chk("t5_live33", bus.BCD, 8'h33);
        cycle(1, 1, 1, 0);
        after_edge();
        chk("t5_run", bus.RUNNING, 8'h00);
        chk("t5_bcd", bus.BCD, 8'h00);
        chk("t5_frozen", bus.FROZEN, 8'h00);

        // Asynchronous reset mid-count.
        cycle(1, 0, 0, 0);
        run(10);
        after_edge();
        chk("t6_pre", bus.BCD, 8'h02);
        do_reset();
        cycle(1, 0, 0, 0);
        run(8);
        after_edge();
        chk("t6_recount", bus.BCD, 8'h02);

        // Random command pulses.
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 19) == 0);
            cl = ($urandom_range(0, 299) == 0);
            lp = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end else begin
                cycle(st, sp, cl, lp);
            end
        end
        run(2);
        after_edge();
        after_edge();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
